ram_dp: RTL and testbench
=========================

# ram_dp

Simple dual-port synchronous RAM that supersedes the single-port scratch RAM. It has one write port and one read port, both usable in the same cycle, with per-byte write strobes and write-first collision forwarding. An init state machine clears the whole array to zero after reset. It sits behind the core's load/store unit as data memory, and anywhere else the datapath needs concurrent read and write access.

## Interface
- XLen, 32, data word width in bits; must be a multiple of 8.
- NPos, 1024, number of words; any value ≥ 2, not required to be a power of two.
- NPosWidth, $clog2(NPos), address width (derived, not overridable).
- NBytes, XLen/8, number of byte lanes (derived).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- ready_o  out  1  high once init is complete; requests are ignored while low.
- we_i  in  1  write request.
- wa_i  in  NPosWidth  write address.
- wd_i  in  XLen  write data.
- wbe_i  in  NBytes  byte strobes; bit k enables wd_i[8k+7:8k].
- re_i  in  1  read request.
- ra_i  in  NPosWidth  read address.
- rd_o  out  XLen  read data; valid only while rvalid_o is high.
- rvalid_o  out  1  one-cycle pulse marking rd_o valid.

## Operation
- FSM states: INIT and RUN. Reset forces INIT with the init counter at 0.
- INIT:
  - Each cycle, write 0 to mem[cnt] and increment cnt.
  - When cnt == NPos-1, write that entry, then go to RUN. INIT lasts exactly NPos cycles.
  - While in INIT: ready_o=0, we_i and re_i are ignored, rvalid_o=0.
- RUN:
  - ready_o=1.
  - Write with we_i=1: for each lane k, mem[wa_i] byte k ← wd_i byte k if wbe_i[k], else it keeps its old value.
  - we_i=1 with wbe_i=0 is a no-op.
- Read with re_i=1 returns mem[ra_i] with rvalid_o=1 after the latency given under Timing.
- Collision (we_i, re_i both high and wa_i == ra_i): the read returns the merged post-write word (write-first). Lanes not strobed return their old bytes.
- Out-of-range addresses (≥ NPos, possible only when NPos is not a power of two):
  - A write is dropped.
  - A read returns all-zero with rvalid_o=1.
- Reset mid-operation:
  - Any in-flight read is discarded: rvalid_o drops immediately (asynchronously).
  - The FSM restarts INIT and the array is re-cleared.
- There is no back-pressure. A read can be issued every cycle, and responses return in order.

## Timing
- Reset values: ready_o=0, rvalid_o=0, rd_o=0, FSM=INIT, cnt=0.
- ready_o rises on the clock edge that completes the NPos-th init write. The first accepted request is on the following edge.
- Read latency is 1 cycle: a request at edge n gives rd_o/rvalid_o valid after edge n, and they are sampled at edge n+1.
- rd_o holds its last value when rvalid_o=0.
- A write at edge n is visible to a read issued at edge n (forwarding) and at any later edge.
- The array itself has no reset. Only INIT clears its contents.

## Configuration
- RAM_DP_OUT_REG_EN defined:
  - An extra output register is added on rd_o/rvalid_o, so read latency is 2 cycles.
  - Reset clears both pipeline stages.
  - Forwarding is still applied at the array stage.
- Undefined: read latency is 1 cycle, as described above.

## Structure
- Package ram_dp_pkg holds:
  - the state enum (INIT, RUN);
  - default XLen/NPos constants;
  - a function computing the byte-strobe merge (old word, new word, strobes → merged word).
- One sub-module, ram_dp_array: a pure storage array with a byte-enabled write port and a registered read port, with no reset, so synthesis infers block RAM.
- The top level holds:
  - the init FSM and counter;
  - the write mux (init vs. user);
  - collision compare and forwarding;
  - the optional output stage.

## Test plan
- Reset, then wait: ready_o stays 0 for exactly NPos cycles, then rises. Reads of addresses 0, NPos/2 and NPos-1 return 0x00000000.
- Write 0xDEADBEEF to address 5 with wbe=4'b1111, then read 5 → rd_o=0xDEADBEEF, with rvalid_o one cycle after the request (two with RAM_DP_OUT_REG_EN).
- Starting from 0xDEADBEEF at address 5, write 0x11223344 with wbe=4'b0101 → read returns 0xDE22BE44.
- Same-cycle write 0xA5A5A5A5 (wbe=4'b1111) and read at address 9 → rd_o=0xA5A5A5A5. Same-cycle read at address 10 → old contents.
- Assert rst_i during a back-to-back read burst → rvalid_o drops immediately and ready_o=0. After NPos cycles, previously written addresses read 0.
- With NPos=1000: write to address 1010 → no array change; read of 1010 → 0 with rvalid_o=1.

Source files
------------

// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg: shared types, default sizes and byte-strobe merge helper for ram_dp
package ram_dp_pkg;
    typedef enum logic {INIT, RUN} state_t;
    localparam int XLEN_DEF = 32;
    localparam int NPOS_DEF = 1024;
    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_XLEN = 512;
    typedef logic [MAX_XLEN-1:0]   word_t;
    typedef logic [MAX_XLEN/8-1:0] strb_t;
    // Merged word: byte k from new_w where be[k] is set, otherwise from old_w.
    function automatic word_t byte_merge(input word_t old_w, input word_t new_w, input strb_t be);
        word_t m;
        m = old_w;
        for (int k = 0; k < MAX_XLEN/8; k++)
            m[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return m;
    endfunction
endpackage

// File: rtl/ram_dp_array.sv
// ram_dp_array: reset-free storage with byte-enabled write and registered read (read-first)
// Ports: clk_i clock; we_i/wa_i/wd_i/wbe_i byte-enabled write port;
//        re_i/ra_i read request; rd_o registered read data (holds when re_i=0).
module ram_dp_array #(
    parameter int XLen = 32,
    parameter int NPos = 1024,
    localparam int AW  = $clog2(NPos),
    localparam int NB  = XLen / 8
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLen-1:0] wd_i,
    input  logic [NB-1:0]   wbe_i,
    input  logic            re_i,
    input  logic [AW-1:0]   ra_i,
    output logic [XLen-1:0] rd_o
);
    logic [XLen-1:0] mem [NPos];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NB; k++)
            if (we_i && wbe_i[k]) mem[wa_i][8*k +: 8] <= wd_i[8*k +: 8];
        if (re_i) rd_o <= mem[ra_i];
    end
endmodule

// File: rtl/ram_dp.sv
// ram_dp: dual-port RAM with byte strobes, write-first forwarding and post-reset zero-init
// Ports: clk_i clock; rst_i async active-high reset; ready_o high once init is done;
//        we_i/wa_i/wd_i/wbe_i write port; re_i/ra_i read request;
//        rd_o/rvalid_o read response (rd_o holds while rvalid_o is low).
// Option: define RAM_DP_OUT_REG_EN to add an output register (read latency 2).
module ram_dp
    import ram_dp_pkg::*;
#(
    parameter int XLen       = XLEN_DEF,
    parameter int NPos       = NPOS_DEF,
    localparam int NPosWidth = $clog2(NPos),
    localparam int NBytes    = XLen / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 ready_o,
    input  logic                 we_i,
    input  logic [NPosWidth-1:0] wa_i,
    input  logic [XLen-1:0]      wd_i,
    input  logic [NBytes-1:0]    wbe_i,
    input  logic                 re_i,
    input  logic [NPosWidth-1:0] ra_i,
    output logic [XLen-1:0]      rd_o,
    output logic                 rvalid_o
);
    localparam logic [NPosWidth-1:0] LAST  = NPosWidth'(NPos - 1);
    localparam logic [NPosWidth:0]   LIMIT = (NPosWidth + 1)'(NPos);

    state_t                state;
    logic [NPosWidth-1:0]  cnt;
    logic                  init, w_ok, r_ok, acc_w, acc_r, col;
    logic [XLen-1:0]       arr_rd, rd1;
    logic                  rvalid1, zero_q, col_q;
    logic [XLen-1:0]       wd_q;
    logic [NBytes-1:0]     wbe_q;

    assign init  = state == INIT;
    assign w_ok  = {1'b0, wa_i} < LIMIT;
    assign r_ok  = {1'b0, ra_i} < LIMIT;
    assign acc_w = ready_o & we_i & w_ok;
    assign acc_r = ready_o & re_i;
    assign col   = acc_w & acc_r & (wa_i == ra_i);

    // Init owns the write port until every entry has been cleared.
    ram_dp_array #(.XLen(XLen), .NPos(NPos)) u_array (
        .clk_i (clk_i),
        .we_i  (init | acc_w),
        .wa_i  (init ? cnt : wa_i),
        .wd_i  (init ? '0 : wd_i),
        .wbe_i (init ? '1 : wbe_i),
        .re_i  (acc_r & r_ok),
        .ra_i  (ra_i),
        .rd_o  (arr_rd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= INIT;
            cnt     <= '0;
            ready_o <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state   <= RUN;
                ready_o <= 1'b1;
            end
        end
    end

    // Side info captured only on accepted reads so rd1 holds between reads.
    // zero_q starts set so rd1 is zero before the (unreset) array is first read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid1 <= 1'b0;
            zero_q  <= 1'b1;
            col_q   <= 1'b0;
            wd_q    <= '0;
            wbe_q   <= '0;
        end else begin
            rvalid1 <= acc_r;
            if (acc_r) begin
                zero_q <= !r_ok;
                col_q  <= col;
                wd_q   <= wd_i;
                wbe_q  <= wbe_i;
            end
        end
    end

    // The array reads the pre-write word; a collision overlays the strobed bytes.
    assign rd1 = zero_q ? '0 :
                 col_q  ? XLen'(byte_merge(word_t'(arr_rd), word_t'(wd_q), strb_t'(wbe_q))) :
                          arr_rd;

`ifdef RAM_DP_OUT_REG_EN
    logic [XLen-1:0] rd_q;
    logic            rvalid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid1;
            if (rvalid1) rd_q <= rd1;
        end
    end

    assign rd_o     = rd_q;
    assign rvalid_o = rvalid_q;
`else
    assign rd_o     = rd1;
    assign rvalid_o = rvalid1;
`endif
endmodule

// File: tb/tb_ram_dp.sv
// tb_ram_dp: randomized scoreboard bench for ram_dp against an array reference model
module tb_ram_dp;
    localparam int NP = 1000;
`ifdef RAM_DP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0, rst_i = 1'b1;
    logic        ready_o, we_i = 1'b0, re_i = 1'b0, rvalid_o;
    logic [9:0]  wa_i = '0, ra_i = '0;
    logic [31:0] wd_i = '0, rd_o;
    logic [3:0]  wbe_i = '0;

    ram_dp #(.XLen(32), .NPos(NP)) dut (
        .clk_i(clk), .rst_i(rst_i), .ready_o(ready_o),
        .we_i(we_i), .wa_i(wa_i), .wd_i(wd_i), .wbe_i(wbe_i),
        .re_i(re_i), .ra_i(ra_i), .rd_o(rd_o), .rvalid_o(rvalid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [31:0] d; int due; } exp_t;
    exp_t        q[$];
    exp_t        e;
    logic [31:0] model [NP];
    logic [31:0] last_rd = '0;
    int          total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (rvalid_o) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 with no read outstanding (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("rd", rd_o, e.d);
                    chk("latency", cyc, e.due);
                end
                last_rd = rd_o;
            end else chk("hold", rd_o, last_rd);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < NP; i++) model[i] = '0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_cycles", n, NP);
        chk("ready", 32'(ready_o), 32'd1);
    endtask

    // Drives one cycle of requests; the model applies the write before the read (write-first).
    task automatic issue(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] wbe,
                         input bit re, input int ra);
        exp_t x;
        we_i = we; wa_i = wa[9:0]; wd_i = wd; wbe_i = wbe;
        re_i = re; ra_i = ra[9:0];
        if (we && wa < NP)
            for (int k = 0; k < 4; k++)
                if (wbe[k]) model[wa][8*k +: 8] = wd[8*k +: 8];
        if (re) begin
            x.d   = (ra < NP) ? model[ra] : 32'h0;
            x.due = cyc + LAT;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        we_i = 1'b0;
        re_i = 1'b0;
    endtask

    task automatic rd(input int a);
        issue(1'b0, 0, 32'h0, 4'h0, 1'b1, a);
    endtask

    function automatic int pick();
        return ($urandom % 10 == 0) ? int'($urandom_range(1023, 1000)) : int'($urandom_range(15, 0));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rd", rd_o, 32'h0);
        idle(2);
        // Requests held during init must be ignored.
        we_i = 1'b1; wa_i = 10'd3; wd_i = 32'hFFFF_FFFF; wbe_i = 4'hF;
        re_i = 1'b1; ra_i = 10'd3;
        rst_i = 1'b0;
        wait_ready();
        we_i = 1'b0;
        re_i = 1'b0;
        clear_model();
        rd(0); rd(NP/2); rd(NP-1); rd(3);
        issue(1'b1, 5, 32'hDEAD_BEEF, 4'b1111, 1'b0, 0);
        rd(5);
        issue(1'b1, 5, 32'h1122_3344, 4'b0101, 1'b0, 0);
        rd(5);
        issue(1'b1, 9, 32'hA5A5_A5A5, 4'b1111, 1'b1, 9);
        issue(1'b1, 10, 32'h1234_5678, 4'b1111, 1'b0, 0);
        issue(1'b1, 9, 32'h5A5A_5A5A, 4'b1111, 1'b1, 10);
        rd(9);
        issue(1'b1, 5, 32'hFFFF_0000, 4'b1100, 1'b1, 5);
        issue(1'b1, 7, 32'h0BAD_F00D, 4'b0000, 1'b1, 7);
        issue(1'b1, 1010, 32'hCAFE_BABE, 4'b1111, 1'b1, 1010);
        rd(1010); rd(1023); rd(NP-1);
        for (int i = 0; i < 500; i++) begin
            int wa, ra;
            wa = pick();
            ra = ($urandom % 3 == 0) ? wa : pick();
            issue(1'($urandom), wa, $urandom, 4'($urandom), ($urandom % 4) != 0, ra);
            if ($urandom % 8 == 0) idle(1);
        end
        idle(LAT + 2);
        chk("drained", q.size(), 0);
        // Reset in the middle of a back-to-back read burst.
        rd(5); rd(9); rd(10);
        rst_i = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(rvalid_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        chk("midrst_rd", rd_o, 32'h0);
        q.delete();
        last_rd = '0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        wait_ready();
        clear_model();
        rd(5); rd(9); rd(10); rd(7);
        idle(LAT + 2);
        chk("drained_end", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
